// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with count-based status flags and one-cycle overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module param_sync_fifo #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [DATA_W-1:0]       D_in,
  input  logic                    rd,
  output logic [DATA_W-1:0]       D_out,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  fifo_cnt,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CntMax = CW'(DEPTH);
  localparam logic [CW-1:0] AfLvl  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeLvl  = CW'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_cnt;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_rd_acc;
  logic              w_wr_acc;

  assign full         = (r_cnt == CntMax);
  assign empty        = (r_cnt == '0);
  assign almost_full  = (r_cnt >= AfLvl);
  assign almost_empty = (r_cnt <= AeLvl);
  assign fifo_cnt     = r_cnt;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // A full FIFO still takes a write when the same cycle pops a word.
  assign w_rd_acc = rd & ~empty;
  assign w_wr_acc = wr & (~full | w_rd_acc);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr & ~w_wr_acc;
      r_underflow <= rd & ~w_rd_acc;
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (rst && w_wr_acc) r_mem[r_wptr] <= D_in;
  end

`ifdef FIFO_FWFT_EN
  assign D_out    = empty ? '0 : r_mem[r_rptr];
  assign rd_valid = ~empty;
`else
  logic [DATA_W-1:0] r_dout;
  logic              r_rd_valid;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_dout     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_dout <= r_mem[r_rptr];
    end
  end

  assign D_out    = r_dout;
  assign rd_valid = r_rd_valid;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: vector table plus hand sequences for fill/drain,
// overflow/underflow, wrap under simultaneous read+write, and asynchronous reset.
module tb_param_sync_fifo;

  localparam int unsigned DW = 128;
  localparam int unsigned DP = 16;
  localparam int unsigned CW = $clog2(DP) + 1;

  logic          clock = 1'b0;
  logic          rst;
  logic          wr;
  logic [DW-1:0] D_in;
  logic          rd;
  logic [DW-1:0] D_out;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] fifo_cnt;
  logic          overflow;
  logic          underflow;

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_rd;

  typedef struct {
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    int            cnt;
    logic          fl;
    logic          em;
    logic          af;
    logic          ae;
    logic          ov;
    logic          un;
  } vec_t;

  vec_t vecs[5];

  param_sync_fifo #(
    .DATA_W(DW),
    .DEPTH (DP)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .wr          (wr),
    .D_in        (D_in),
    .rd          (rd),
    .D_out       (D_out),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fifo_cnt    (fifo_cnt),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, return 1 time unit after the rising edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    wr = w; rd = r; D_in = d;
    @(posedge clock);
    #1;
    wr = 1'b0; rd = 1'b0; D_in = '0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1'b1, 1'b0, d);
    q.push_back(d);
  endtask

  task automatic pop(input string name);
    logic [DW-1:0] exp;
    exp = q.pop_front();
`ifdef FIFO_FWFT_EN
    chk({name, "_valid"}, DW'(rd_valid), DW'(1));
    chk(name, D_out, exp);
    step(1'b0, 1'b1, '0);
`else
    step(1'b0, 1'b1, '0);
    chk({name, "_valid"}, DW'(rd_valid), DW'(1));
    chk(name, D_out, exp);
`endif
    last_rd = exp;
  endtask

  task automatic pushpop(input logic [DW-1:0] d);
    logic [DW-1:0] exp;
    exp = q.pop_front();
`ifdef FIFO_FWFT_EN
    chk("rw_data", D_out, exp);
    step(1'b1, 1'b1, d);
`else
    step(1'b1, 1'b1, d);
    chk("rw_data", D_out, exp);
`endif
    q.push_back(d);
    chk("rw_cnt", DW'(fifo_cnt), DW'(DP));
    chk("rw_ovf", DW'(overflow), DW'(0));
  endtask

  initial begin
    rst = 1'b0; wr = 1'b0; rd = 1'b0; D_in = '0;
    #1;
    chk("rst_empty", DW'(empty), DW'(1));
    chk("rst_aempty", DW'(almost_empty), DW'(1));
    chk("rst_full", DW'(full), DW'(0));
    chk("rst_afull", DW'(almost_full), DW'(0));
    chk("rst_cnt", DW'(fifo_cnt), DW'(0));
    chk("rst_ovf", DW'(overflow), DW'(0));
    chk("rst_udf", DW'(underflow), DW'(0));
    chk("rst_valid", DW'(rd_valid), DW'(0));
    chk("rst_dout", D_out, '0);
    repeat (2) @(posedge clock);
    #2 rst = 1'b1;

    // Underflow on empty, then empty with wr+rd: write taken, read refused.
    vecs[0] = '{w:1'b0, r:1'b1, d:'0,    cnt:0, fl:0, em:1, af:0, ae:1, ov:0, un:1};
    vecs[1] = '{w:1'b1, r:1'b1, d:DW'(5), cnt:1, fl:0, em:0, af:0, ae:1, ov:0, un:1};
    vecs[2] = '{w:1'b0, r:1'b0, d:'0,    cnt:1, fl:0, em:0, af:0, ae:1, ov:0, un:0};
    vecs[3] = '{w:1'b1, r:1'b0, d:DW'(6), cnt:2, fl:0, em:0, af:0, ae:1, ov:0, un:0};
    vecs[4] = '{w:1'b1, r:1'b0, d:DW'(7), cnt:3, fl:0, em:0, af:0, ae:0, ov:0, un:0};
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].w, vecs[i].r, vecs[i].d);
      chk($sformatf("vec%0d_cnt", i), DW'(fifo_cnt), DW'(vecs[i].cnt));
      chk($sformatf("vec%0d_full", i), DW'(full), DW'(vecs[i].fl));
      chk($sformatf("vec%0d_empty", i), DW'(empty), DW'(vecs[i].em));
      chk($sformatf("vec%0d_af", i), DW'(almost_full), DW'(vecs[i].af));
      chk($sformatf("vec%0d_ae", i), DW'(almost_empty), DW'(vecs[i].ae));
      chk($sformatf("vec%0d_ovf", i), DW'(overflow), DW'(vecs[i].ov));
      chk($sformatf("vec%0d_udf", i), DW'(underflow), DW'(vecs[i].un));
    end
    q.push_back(DW'(5)); q.push_back(DW'(6)); q.push_back(DW'(7));
    pop("vec_rd5");
    pop("vec_rd6");
    pop("vec_rd7");
    chk("vec_drained", DW'(empty), DW'(1));

    // Hold behaviour after a read when idle.
    step(1'b0, 1'b0, '0);
`ifdef FIFO_FWFT_EN
    chk("idle_valid", DW'(rd_valid), DW'(0));
`else
    chk("idle_valid", DW'(rd_valid), DW'(0));
    chk("idle_hold", D_out, last_rd);
`endif

    // Fill 1..16, check thresholds, drain in order.
    for (int i = 1; i <= 16; i++) begin
      push(DW'(i));
      if (i == 13) chk("af_at13", DW'(almost_full), DW'(0));
      if (i == 14) chk("af_at14", DW'(almost_full), DW'(1));
      if (i == 15) chk("full_at15", DW'(full), DW'(0));
    end
    chk("full_at16", DW'(full), DW'(1));
    chk("cnt_at16", DW'(fifo_cnt), DW'(16));
    for (int i = 1; i <= 16; i++) begin
      pop($sformatf("fill_rd%0d", i));
      if (i == 13) chk("ae_at3", DW'(almost_empty), DW'(0));
      if (i == 14) chk("ae_at2", DW'(almost_empty), DW'(1));
    end
    chk("drain_empty", DW'(empty), DW'(1));
    chk("drain_cnt", DW'(fifo_cnt), DW'(0));

    // Overflow while full, then continuous wr+rd across pointer wrap.
    for (int i = 0; i < 16; i++) push(DW'(32'h100 + i));
    step(1'b1, 1'b0, DW'(32'hDEAD));
    chk("ovf_pulse", DW'(overflow), DW'(1));
    chk("ovf_cnt", DW'(fifo_cnt), DW'(16));
    step(1'b0, 1'b0, '0);
    chk("ovf_clear", DW'(overflow), DW'(0));
    for (int i = 0; i < 20; i++) pushpop(DW'(32'h200 + i));
    for (int i = 0; i < 16; i++) pop($sformatf("wrap_rd%0d", i));
    chk("wrap_empty", DW'(empty), DW'(1));

    // Asynchronous reset between edges discards stored data.
    for (int i = 0; i < 5; i++) push(DW'(32'h30 + i));
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", DW'(empty), DW'(1));
    chk("arst_cnt", DW'(fifo_cnt), DW'(0));
    chk("arst_valid", DW'(rd_valid), DW'(0));
    chk("arst_dout", D_out, '0);
    q.delete();
    #2 rst = 1'b1;
    push(DW'(32'h77));
    chk("post_rst_cnt", DW'(fifo_cnt), DW'(1));
    pop("post_rst_rd");
    chk("post_rst_empty", DW'(empty), DW'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
